// File: rtl/vector_lane_sequencer_pkg.sv
// Shared types, encodings and helpers for the vector lane sequencer.
package vector_lane_sequencer_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned STEP_W     = 3;
   localparam int unsigned SHIFT_W    = 5;

   typedef logic [1:0] seq_state_t;
   localparam seq_state_t ST_IDLE   = 2'd0;
   localparam seq_state_t ST_EXEC   = 2'd1;
   localparam seq_state_t ST_RED_WB = 2'd2;
   localparam seq_state_t ST_DONE   = 2'd3;

   typedef logic [1:0] sew_t;
   localparam sew_t SEW_8   = 2'b00;
   localparam sew_t SEW_16  = 2'b01;
   localparam sew_t SEW_32  = 2'b10;
   localparam sew_t SEW_BAD = 2'b11;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] vs1;
      logic [REG_ADDR_W-1:0] vs2;
      logic [REG_ADDR_W-1:0] vd;
      logic                  reduction;
      sew_t                  sew;
   } issue_fields_t;

   function automatic logic [3:0] sew_bytes(input sew_t sew);
      sew_bytes = 4'(1) << sew;
   endfunction

   // log2(elements per register) from log2(bytes per register) and SEW
   function automatic logic [SHIFT_W-1:0] epr_shift(input logic [SHIFT_W-1:0] log_nbytes,
                                                    input sew_t sew);
      epr_shift = log_nbytes - SHIFT_W'(sew);
   endfunction

endpackage

// File: rtl/vector_lane_sequencer_mask_gen.sv
// Byte-granular thermometer mask: the low byte_count bits of mask are set.
module vector_lane_sequencer_mask_gen #(
   parameter int unsigned VLEN  = 128,
   parameter int unsigned CNT_W = $clog2(VLEN/8) + 1
) (
   input  logic [CNT_W-1:0]  byte_count,
   output logic [VLEN/8-1:0] mask
);
   localparam int unsigned NBYTES = VLEN / 8;

   always_comb begin
      mask = '0;
      for (int unsigned i = 0; i < NBYTES; i++) begin
         mask[i] = (CNT_W'(i) < byte_count);
      end
   end

endmodule

// File: rtl/vector_lane_sequencer.sv
// Issue/sequencing controller: strip-mines one vector op across its LMUL group
// and steers PE operands, including the lane ripple and accumulator for reductions.
module vector_lane_sequencer
   import vector_lane_sequencer_pkg::*;
#(
   parameter int unsigned NUM_LANES  = 4,
   parameter int unsigned LANE_WIDTH = 32,
   parameter int unsigned VLEN       = NUM_LANES * LANE_WIDTH,
   parameter int unsigned VL_W       = $clog2(VLEN) + 1,
   parameter int unsigned ETW_W      = $clog2(VLEN/8) + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  issue_valid,
   output logic                  issue_ready,
   input  logic [4:0]            issue_vs1,
   input  logic [4:0]            issue_vs2,
   input  logic [4:0]            issue_vd,
   input  logic                  issue_reduction,
   input  logic [VL_W-1:0]       vl,
   input  logic [1:0]            vsew,
   input  logic [1:0]            vlmul,
   input  logic                  stall,
   input  logic                  flush,
   output logic [4:0]            vs1_addr,
   output logic [4:0]            vs2_addr,
   output logic [4:0]            vd_addr,
   input  logic [VLEN-1:0]       vs1_data,
   input  logic [VLEN-1:0]       pe_out,
   output logic [VLEN-1:0]       pe_b_data,
   output logic [VLEN-1:0]       vd_data,
   output logic                  write,
   output logic [ETW_W-1:0]      elements_to_write,
   output logic [VLEN/8-1:0]     elem_active,
   output logic                  busy,
   output logic                  done,
   output logic                  illegal
);

   localparam int unsigned NBYTES = VLEN / 8;
   localparam int unsigned LOG_NB = $clog2(NBYTES);
   localparam int unsigned VLMAX  = VLEN;
   localparam int unsigned XW     = VL_W + 1;

   seq_state_t             state_q, state_d;
   issue_fields_t          fields_q;
   logic [STEP_W:0]        nregs_q;
   logic [STEP_W-1:0]      step_q;
   logic [VL_W-1:0]        remaining_q;
   logic [LANE_WIDTH-1:0]  acc_q;
   logic                   illegal_q;

   logic [SHIFT_W-1:0]     iss_shift, cur_shift;
   logic [XW-1:0]          iss_epr, iss_nregs, iss_group;
   logic                   iss_illegal;
   logic [VL_W-1:0]        cur_epr, cur_etw;
   logic                   last_step;
   logic [LANE_WIDTH-1:0]  acc_src;
   logic [ETW_W-1:0]       mask_bytes;
   logic                   accept, advance;

   // Configuration checks on the offered instruction
   always_comb begin
      iss_shift   = epr_shift(SHIFT_W'(LOG_NB), sew_t'(vsew));
      iss_epr     = XW'(1) << iss_shift;
      iss_nregs   = (XW'(vl) + iss_epr - XW'(1)) >> iss_shift;
      iss_group   = XW'(1) << vlmul;
      iss_illegal = (vsew == SEW_BAD)
                 || ((32'(sew_bytes(sew_t'(vsew))) * 32'd8) > 32'(LANE_WIDTH))
                 || (iss_nregs > iss_group)
                 || (XW'(vl) > XW'(VLMAX));
   end

   // Per-step quantities for the instruction in flight
   always_comb begin
      cur_shift = epr_shift(SHIFT_W'(LOG_NB), fields_q.sew);
      cur_epr   = VL_W'(1) << cur_shift;
      cur_etw   = (remaining_q < cur_epr) ? remaining_q : cur_epr;
      last_step = ((STEP_W+1)'(step_q) + (STEP_W+1)'(1)) == nregs_q;
      acc_src   = (step_q == '0) ? vs1_data[LANE_WIDTH-1:0] : acc_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Latched instruction fields, step counter, remaining count and accumulator
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fields_q    <= '0;
         nregs_q     <= '0;
         step_q      <= '0;
         remaining_q <= '0;
         acc_q       <= '0;
         illegal_q   <= 1'b0;
      end else if (accept) begin
         fields_q    <= '{vs1: issue_vs1, vs2: issue_vs2, vd: issue_vd,
                          reduction: issue_reduction, sew: sew_t'(vsew)};
         nregs_q     <= (STEP_W+1)'(iss_nregs);
         step_q      <= '0;
         remaining_q <= vl;
         acc_q       <= '0;
         illegal_q   <= iss_illegal;
      end else if (advance) begin
         step_q      <= step_q + STEP_W'(1);
         remaining_q <= remaining_q - cur_etw;
         if (fields_q.reduction) begin
            acc_q <= pe_out[VLEN-1 -: LANE_WIDTH];
         end
      end
   end

   // Next state and decoded outputs
   always_comb begin
      state_d           = state_q;
      accept            = 1'b0;
      advance           = 1'b0;
      issue_ready       = 1'b0;
      busy              = (state_q != ST_IDLE);
      write             = 1'b0;
      done              = 1'b0;
      illegal           = 1'b0;
      vs1_addr          = '0;
      vs2_addr          = '0;
      vd_addr           = '0;
      elements_to_write = '0;
      mask_bytes        = '0;
      pe_b_data         = '0;
      vd_data           = '0;

      case (state_q)
         ST_IDLE: begin
            issue_ready = !reset;
            if (issue_valid && !reset) begin
               accept  = 1'b1;
               state_d = (iss_illegal || (vl == '0)) ? ST_DONE : ST_EXEC;
            end
         end

         ST_EXEC: begin
            vs1_addr          = fields_q.vs1 + 5'(step_q);
            vs2_addr          = fields_q.vs2 + 5'(step_q);
            vd_addr           = fields_q.vd + 5'(step_q);
            elements_to_write = ETW_W'(cur_etw);
            mask_bytes        = ETW_W'(cur_etw) << fields_q.sew;
            if (fields_q.reduction) begin
               // lane 0 takes the running sum, lane k the result of lane k-1
               pe_b_data = (pe_out << LANE_WIDTH) | VLEN'(acc_src);
            end else begin
               pe_b_data = vs1_data;
               vd_data   = pe_out;
            end
            if (flush) begin
               state_d = ST_IDLE;
            end else if (!stall) begin
               advance = 1'b1;
               write   = !fields_q.reduction;
               if (last_step) begin
                  state_d = fields_q.reduction ? ST_RED_WB : ST_DONE;
               end
            end
         end

         ST_RED_WB: begin
            vd_addr           = fields_q.vd;
            vd_data           = VLEN'(acc_q);
            elements_to_write = ETW_W'(1);
            mask_bytes        = ETW_W'(sew_bytes(fields_q.sew));
            if (flush) begin
               state_d = ST_IDLE;
            end else if (!stall) begin
               write   = 1'b1;
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            done    = !flush;
            illegal = !flush && illegal_q;
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   vector_lane_sequencer_mask_gen #(
      .VLEN  (VLEN),
      .CNT_W (ETW_W)
   ) u_mask_gen (
      .byte_count (mask_bytes),
      .mask       (elem_active)
   );

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// Scoreboard bench for vector_lane_sequencer: directed ops with a lane-adder PE model.
module tb_vector_lane_sequencer;

   localparam int unsigned NUM_LANES  = 4;
   localparam int unsigned LANE_WIDTH = 32;
   localparam int unsigned VLEN       = 128;
   localparam int unsigned VL_W       = 8;
   localparam int unsigned ETW_W      = 5;
   localparam int unsigned NB         = 16;
   localparam int unsigned CW         = 128;

   logic              clk = 1'b0;
   logic              reset;
   logic              issue_valid;
   logic              issue_ready;
   logic [4:0]        issue_vs1, issue_vs2, issue_vd;
   logic              issue_reduction;
   logic [VL_W-1:0]   vl;
   logic [1:0]        vsew, vlmul;
   logic              stall, flush;
   logic [4:0]        vs1_addr, vs2_addr, vd_addr;
   logic [VLEN-1:0]   vs1_data, vs2_data, pe_out, pe_b_data, vd_data;
   logic              write;
   logic [ETW_W-1:0]  elements_to_write;
   logic [NB-1:0]     elem_active;
   logic              busy, done, illegal;

   logic [VLEN-1:0]   regs [32];
   int                cyc = 0;
   int                checks = 0;
   int                failures = 0;

   typedef struct packed {
      int               cyc;
      logic [4:0]       addr;
      logic [ETW_W-1:0] etw;
      logic [NB-1:0]    mask;
      logic [VLEN-1:0]  data;
   } wr_t;

   typedef struct packed {
      int   cyc;
      logic ill;
   } dn_t;

   wr_t exp_wr[$];
   dn_t exp_dn[$];
   wr_t mon_w;
   dn_t mon_d;

   vector_lane_sequencer #(.NUM_LANES(NUM_LANES), .LANE_WIDTH(LANE_WIDTH)) dut (
      .clk(clk), .reset(reset),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_vs1(issue_vs1), .issue_vs2(issue_vs2), .issue_vd(issue_vd),
      .issue_reduction(issue_reduction), .vl(vl), .vsew(vsew), .vlmul(vlmul),
      .stall(stall), .flush(flush),
      .vs1_addr(vs1_addr), .vs2_addr(vs2_addr), .vd_addr(vd_addr),
      .vs1_data(vs1_data), .pe_out(pe_out), .pe_b_data(pe_b_data), .vd_data(vd_data),
      .write(write), .elements_to_write(elements_to_write), .elem_active(elem_active),
      .busy(busy), .done(done), .illegal(illegal)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign vs1_data = regs[vs1_addr];
   assign vs2_data = regs[vs2_addr];

   // PE array model: lane k = vs2 lane k + b lane k, settled one lane per ns so the ripple resolves
   initial begin
      pe_out = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int k = 0; k < NUM_LANES; k++) begin
            pe_out[k*LANE_WIDTH +: LANE_WIDTH] = vs2_data[k*LANE_WIDTH +: LANE_WIDTH]
                                               + pe_b_data[k*LANE_WIDTH +: LANE_WIDTH];
            #1;
         end
      end
   end

   task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [VLEN-1:0] lane_add(input logic [VLEN-1:0] a, input logic [VLEN-1:0] b);
      logic [VLEN-1:0] r;
      for (int k = 0; k < NUM_LANES; k++)
         r[k*LANE_WIDTH +: LANE_WIDTH] = a[k*LANE_WIDTH +: LANE_WIDTH] + b[k*LANE_WIDTH +: LANE_WIDTH];
      return r;
   endfunction

   task automatic push_wr(input int c, input int addr, input int etw, input int mask,
                          input logic [VLEN-1:0] data);
      wr_t w;
      w.cyc  = c;
      w.addr = 5'(addr);
      w.etw  = ETW_W'(etw);
      w.mask = NB'(mask);
      w.data = data;
      exp_wr.push_back(w);
   endtask

   task automatic push_dn(input int c, input logic ill);
      dn_t d;
      d.cyc = c;
      d.ill = ill;
      exp_dn.push_back(d);
   endtask

   // Monitor: pops the scoreboard whenever the DUT writes or signals completion
   always @(negedge clk) begin
      if (write) begin
         if (exp_wr.size() == 0) begin
            chk("unexpected_write", CW'(vd_addr), CW'(0) - CW'(1));
         end else begin
            mon_w = exp_wr.pop_front();
            chk("write_cycle", CW'(cyc), CW'(mon_w.cyc));
            chk("vd_addr", CW'(vd_addr), CW'(mon_w.addr));
            chk("elements_to_write", CW'(elements_to_write), CW'(mon_w.etw));
            chk("elem_active", CW'(elem_active), CW'(mon_w.mask));
            chk("vd_data", CW'(vd_data), CW'(mon_w.data));
         end
      end
      if (done) begin
         if (exp_dn.size() == 0) begin
            chk("unexpected_done", CW'(done), CW'(0));
         end else begin
            mon_d = exp_dn.pop_front();
            chk("done_cycle", CW'(cyc), CW'(mon_d.cyc));
            chk("illegal_flag", CW'(illegal), CW'(mon_d.ill));
         end
      end else if (illegal) begin
         chk("illegal_without_done", CW'(illegal), CW'(0));
      end
   end

   task automatic do_issue(input int s1, input int s2, input int d, input logic red,
                           input int l, input int sew, input int lmul, output int t);
      @(negedge clk);
      issue_valid     = 1'b1;
      issue_vs1       = 5'(s1);
      issue_vs2       = 5'(s2);
      issue_vd        = 5'(d);
      issue_reduction = red;
      vl              = VL_W'(l);
      vsew            = 2'(sew);
      vlmul           = 2'(lmul);
      chk("issue_ready", CW'(issue_ready), CW'(1));
      @(posedge clk);
      #1;
      issue_valid = 1'b0;
      t = cyc;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (busy) chk({name, "_timeout"}, CW'(busy), CW'(0));
      chk({name, "_writes_drained"}, CW'(exp_wr.size()), CW'(0));
      chk({name, "_dones_drained"}, CW'(exp_dn.size()), CW'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      reset = 1'b1;
      issue_valid = 1'b0; issue_vs1 = '0; issue_vs2 = '0; issue_vd = '0;
      issue_reduction = 1'b0; vl = '0; vsew = '0; vlmul = '0;
      stall = 1'b0; flush = 1'b0;
      for (int i = 0; i < 32; i++)
         for (int k = 0; k < NUM_LANES; k++)
            regs[i][k*LANE_WIDTH +: LANE_WIDTH] = 32'(i * 256 + k);
      regs[16][31:0] = 32'd10;
      regs[20] = {32'd4, 32'd3, 32'd2, 32'd1};
      regs[21] = {32'd8, 32'd7, 32'd6, 32'd5};

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_issue_ready", CW'(issue_ready), CW'(0));
      chk("rst_busy", CW'(busy), CW'(0));
      chk("rst_write", CW'(write), CW'(0));
      chk("rst_vd_data", CW'(vd_data), CW'(0));
      chk("rst_elem_active", CW'(elem_active), CW'(0));
      reset = 1'b0;
      #1;
      chk("rel_issue_ready", CW'(issue_ready), CW'(1));

      // single-register SEW8 op
      do_issue(2, 4, 6, 1'b0, 16, 0, 0, t);
      push_wr(t, 6, 16, 'hFFFF, lane_add(regs[2], regs[4]));
      push_dn(t + 1, 1'b0);
      wait_idle("sew8_single");

      // two-register SEW32 op with a partial tail
      do_issue(8, 10, 12, 1'b0, 6, 2, 1, t);
      push_wr(t, 12, 4, 'hFFFF, lane_add(regs[8], regs[10]));
      push_wr(t + 1, 13, 2, 'h00FF, lane_add(regs[9], regs[11]));
      push_dn(t + 2, 1'b0);
      wait_idle("sew32_tail");

      // reduction add: 10 + (1..8) = 46
      do_issue(16, 20, 24, 1'b1, 8, 2, 1, t);
      push_wr(t + 2, 24, 1, 'h000F, VLEN'(46));
      push_dn(t + 3, 1'b0);
      wait_idle("reduction");

      // four-register op stalled three cycles in step 1, vd group wraps past 31
      do_issue(0, 4, 30, 1'b0, 16, 2, 2, t);
      push_wr(t, 30, 4, 'hFFFF, lane_add(regs[0], regs[4]));
      push_wr(t + 4, 31, 4, 'hFFFF, lane_add(regs[1], regs[5]));
      push_wr(t + 5, 0, 4, 'hFFFF, lane_add(regs[2], regs[6]));
      push_wr(t + 6, 1, 4, 'hFFFF, lane_add(regs[3], regs[7]));
      push_dn(t + 7, 1'b0);
      @(posedge clk); #1;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_vd_addr", CW'(vd_addr), CW'(31));
         chk("stall_vs1_addr", CW'(vs1_addr), CW'(1));
         chk("stall_write", CW'(write), CW'(0));
         @(posedge clk); #1;
      end
      stall = 1'b0;
      wait_idle("stall");

      // degenerate configurations
      do_issue(0, 0, 0, 1'b0, 0, 0, 0, t);
      push_dn(t, 1'b0);
      wait_idle("vl_zero");
      do_issue(0, 0, 0, 1'b0, 4, 3, 0, t);
      push_dn(t, 1'b1);
      wait_idle("sew_illegal");
      do_issue(0, 0, 0, 1'b0, 20, 2, 0, t);
      push_dn(t, 1'b1);
      wait_idle("group_overflow");

      // flush at step 2 of 4, then a normal op
      do_issue(0, 4, 30, 1'b0, 16, 2, 2, t);
      push_wr(t, 30, 4, 'hFFFF, lane_add(regs[0], regs[4]));
      push_wr(t + 1, 31, 4, 'hFFFF, lane_add(regs[1], regs[5]));
      @(posedge clk); #1;
      @(posedge clk); #1;
      flush = 1'b1;
      #1;
      chk("flush_write", CW'(write), CW'(0));
      chk("flush_done", CW'(done), CW'(0));
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_busy", CW'(busy), CW'(0));
      chk("flush_ready", CW'(issue_ready), CW'(1));
      wait_idle("flush");
      do_issue(2, 4, 6, 1'b0, 16, 0, 0, t);
      push_wr(t, 6, 16, 'hFFFF, lane_add(regs[2], regs[4]));
      push_dn(t + 1, 1'b0);
      wait_idle("after_flush");

      // asynchronous reset mid-EXEC, then a normal op
      do_issue(0, 4, 30, 1'b0, 16, 2, 2, t);
      push_wr(t, 30, 4, 'hFFFF, lane_add(regs[0], regs[4]));
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      chk("arst_busy", CW'(busy), CW'(0));
      chk("arst_write", CW'(write), CW'(0));
      chk("arst_ready", CW'(issue_ready), CW'(0));
      chk("arst_vd_addr", CW'(vd_addr), CW'(0));
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("arst_rel_ready", CW'(issue_ready), CW'(1));
      wait_idle("async_reset");
      do_issue(8, 10, 12, 1'b0, 6, 2, 1, t);
      push_wr(t, 12, 4, 'hFFFF, lane_add(regs[8], regs[10]));
      push_wr(t + 1, 13, 2, 'h00FF, lane_add(regs[9], regs[11]));
      push_dn(t + 2, 1'b0);
      wait_idle("after_reset");

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
